// File: rtl/dino_pkg.sv
// Shared definitions for the dino game blocks: FSM encoding and default
// physics constants used by the player, obstacle and collision logic.
package dino_pkg;

  localparam int DEF_POS_W     = 7;
  localparam int DEF_JUMP_VEL  = 8;
  localparam int DEF_GRAVITY   = 1;
  localparam int DEF_FAST_FALL = 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RUN  = 3'd1;
  localparam logic [2:0] JUMP = 3'd2;
  localparam logic [2:0] DUCK = 3'd3;
  localparam logic [2:0] DEAD = 3'd4;

  function automatic logic is_frozen(input logic [2:0] s);
    return (s == IDLE) || (s == DEAD);
  endfunction

endpackage

// File: rtl/player_physics.sv
// Combinational vertical physics for one airborne tick: integrates velocity
// into height with ground clamp and ceiling saturation, then applies gravity.
module player_physics #(
  parameter int POS_W     = dino_pkg::DEF_POS_W,
  parameter int GRAVITY   = dino_pkg::DEF_GRAVITY,
  parameter int FAST_FALL = dino_pkg::DEF_FAST_FALL
)(
  input  logic               [POS_W-1:0] y,
  input  logic signed        [POS_W:0]   vel,
  input  logic                           button_down,
  output logic               [POS_W-1:0] next_y,
  output logic signed        [POS_W:0]   next_vel,
  output logic                           landed
);

  localparam logic signed [POS_W:0] DEC_SLOW = (POS_W+1)'(GRAVITY);
  localparam logic signed [POS_W:0] DEC_FAST = (POS_W+1)'(GRAVITY + FAST_FALL);

  logic signed [POS_W+1:0] sum;

  // Two guard bits: the top one flags a negative sum, the next one overflow past the ceiling.
  assign sum      = $signed({2'b00, y}) + $signed({vel[POS_W], vel});
  assign landed   = sum[POS_W+1] | (sum == '0);
  assign next_y   = landed ? '0 : (sum[POS_W] ? {POS_W{1'b1}} : sum[POS_W-1:0]);
  assign next_vel = vel - (button_down ? DEC_FAST : DEC_SLOW);

endmodule

// File: rtl/player_controller.sv
// Game-phase FSM and player vertical state; physics per tick via player_physics.
// Optional mid-air second jump is enabled by defining DOUBLE_JUMP_EN.
module player_controller
  import dino_pkg::*;
#(
  parameter int POS_W     = dino_pkg::DEF_POS_W,
  parameter int JUMP_VEL  = dino_pkg::DEF_JUMP_VEL,
  parameter int GRAVITY   = dino_pkg::DEF_GRAVITY,
  parameter int FAST_FALL = dino_pkg::DEF_FAST_FALL
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             game_tick,
  input  logic             button_start,
  input  logic             button_up,
  input  logic             button_down,
  input  logic             crash,
  output logic [POS_W-1:0] player_y,
  output logic             jumping,
  output logic             ducking,
  output logic             game_frozen,
  output logic             game_restart
);

  localparam logic signed [POS_W:0] LAUNCH_VEL = (POS_W+1)'(JUMP_VEL);

  logic [2:0]              state;
  logic [2:0]              next_state;
  logic signed [POS_W:0]   vel;
  logic signed [POS_W:0]   next_vel;
  logic [POS_W-1:0]        next_y;
  logic                    restart_req;

  logic [POS_W-1:0]        phys_y;
  logic signed [POS_W:0]   phys_vel;
  logic                    phys_landed;

`ifdef DOUBLE_JUMP_EN
  logic prev_up;
  logic dj_used;
  logic next_dj;
`endif

  player_physics #(
    .POS_W     (POS_W),
    .GRAVITY   (GRAVITY),
    .FAST_FALL (FAST_FALL)
  ) u_physics (
    .y           (player_y),
    .vel         (vel),
    .button_down (button_down),
    .next_y      (phys_y),
    .next_vel    (phys_vel),
    .landed      (phys_landed)
  );

  // Crash outranks every live-state action; height freezes where it was hit.
  always_comb begin
    next_state  = state;
    next_y      = player_y;
    next_vel    = vel;
    restart_req = 1'b0;
`ifdef DOUBLE_JUMP_EN
    next_dj     = dj_used;
`endif
    case (state)
      IDLE, DEAD: begin
        if (button_start) begin
          next_state  = RUN;
          next_y      = '0;
          next_vel    = '0;
          restart_req = 1'b1;
`ifdef DOUBLE_JUMP_EN
          next_dj     = 1'b0;
`endif
        end
      end
      RUN, DUCK, JUMP: begin
        if (crash) begin
          next_state = DEAD;
          next_vel   = '0;
`ifdef DOUBLE_JUMP_EN
          next_dj    = 1'b0;
`endif
        end else if (state == JUMP) begin
          if (phys_landed) begin
            next_state = button_down ? DUCK : RUN;
            next_y     = '0;
            next_vel   = '0;
`ifdef DOUBLE_JUMP_EN
            next_dj    = 1'b0;
`endif
          end else begin
            next_y   = phys_y;
            next_vel = phys_vel;
`ifdef DOUBLE_JUMP_EN
            if (button_up && !prev_up && !dj_used) begin
              next_vel = LAUNCH_VEL;
              next_dj  = 1'b1;
            end
`endif
          end
        end else if (button_up) begin
          next_state = JUMP;
          next_y     = '0;
          next_vel   = LAUNCH_VEL;
        end else if (state == RUN) begin
          if (button_down) next_state = DUCK;
        end else if (!button_down) begin
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The restart strobe is the only register that is not gated by game_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      player_y     <= '0;
      vel          <= '0;
      jumping      <= 1'b0;
      ducking      <= 1'b0;
      game_frozen  <= 1'b1;
      game_restart <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      prev_up      <= 1'b0;
      dj_used      <= 1'b0;
`endif
    end else begin
      game_restart <= game_tick && restart_req;
      if (game_tick) begin
        state       <= next_state;
        player_y    <= next_y;
        vel         <= next_vel;
        jumping     <= (next_state == JUMP);
        ducking     <= (next_state == DUCK);
        game_frozen <= is_frozen(next_state);
`ifdef DOUBLE_JUMP_EN
        prev_up     <= button_up;
        dj_used     <= next_dj;
`endif
      end
    end
  end

endmodule

// File: tb/tb_player_controller.sv
// Self-checking bench for player_controller: a behavioural model fills a
// scoreboard per tick, and scenario tasks add fixed-value checks.
module tb_player_controller;
  import dino_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 game_tick;
  logic                 button_start;
  logic                 button_up;
  logic                 button_down;
  logic                 crash;
  logic [DEF_POS_W-1:0] player_y;
  logic                 jumping;
  logic                 ducking;
  logic                 game_frozen;
  logic                 game_restart;

  always #5 clk = ~clk;

  player_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_tick    (game_tick),
    .button_start (button_start),
    .button_up    (button_up),
    .button_down  (button_down),
    .crash        (crash),
    .player_y     (player_y),
    .jumping      (jumping),
    .ducking      (ducking),
    .game_frozen  (game_frozen),
    .game_restart (game_restart)
  );

  typedef struct packed {
    logic [DEF_POS_W-1:0] y;
    logic                 j;
    logic                 d;
    logic                 f;
    logic                 r;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [2:0] m_state;
  int         m_y;
  int         m_vel;
  bit         m_prev;
  bit         m_dj;

  logic mon_t;
  exp_t mon_e;

  task automatic model_reset();
    m_state = IDLE;
    m_y     = 0;
    m_vel   = 0;
    m_prev  = 0;
    m_dj    = 0;
    sb.delete();
  endtask

  // Drive one game tick, advance the model and queue what the DUT must show after it.
  task automatic do_tick(input bit st, input bit up, input bit dn, input bit cr);
    exp_t e;
    int   sum;
    int   nv;
    bit   rs;
    @(negedge clk);
    button_start = st;
    button_up    = up;
    button_down  = dn;
    crash        = cr;
    game_tick    = 1'b1;
    rs = 0;
    if (m_state == IDLE || m_state == DEAD) begin
      if (st) begin
        m_state = RUN; m_y = 0; m_vel = 0; m_dj = 0; rs = 1;
      end
    end else if (cr) begin
      m_state = DEAD; m_vel = 0; m_dj = 0;
    end else if (m_state == JUMP) begin
      sum = m_y + m_vel;
      nv  = m_vel - DEF_GRAVITY - (dn ? DEF_FAST_FALL : 0);
`ifdef DOUBLE_JUMP_EN
      if (up && !m_prev && !m_dj) begin
        nv   = DEF_JUMP_VEL;
        m_dj = 1;
      end
`endif
      if (sum <= 0) begin
        m_state = dn ? DUCK : RUN; m_y = 0; m_vel = 0; m_dj = 0;
      end else begin
        m_y   = (sum > (1 << DEF_POS_W) - 1) ? (1 << DEF_POS_W) - 1 : sum;
        m_vel = nv;
      end
    end else if (up) begin
      m_state = JUMP; m_y = 0; m_vel = DEF_JUMP_VEL;
    end else if (m_state == RUN) begin
      if (dn) m_state = DUCK;
    end else if (!dn) begin
      m_state = RUN;
    end
    m_prev = up;
    e.y = m_y[DEF_POS_W-1:0];
    e.j = (m_state == JUMP);
    e.d = (m_state == DUCK);
    e.f = (m_state == IDLE) || (m_state == DEAD);
    e.r = rs;
    sb.push_back(e);
    @(negedge clk);
    game_tick = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard consumer: pop after every ticked edge, otherwise the restart strobe must be low.
  always @(posedge clk) begin
    mon_t = game_tick;
    #1;
    if (mon_t) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("[TB] FAIL sb_underflow: got tick with no expectation, required queued entry");
      end else begin
        mon_e = sb.pop_front();
        n_vec++;
        if (player_y !== mon_e.y) begin
          n_err++; $display("[TB] FAIL sb_y: got %0d required %0d", player_y, mon_e.y);
        end
        n_vec++;
        if (jumping !== mon_e.j) begin
          n_err++; $display("[TB] FAIL sb_jumping: got %b required %b", jumping, mon_e.j);
        end
        n_vec++;
        if (ducking !== mon_e.d) begin
          n_err++; $display("[TB] FAIL sb_ducking: got %b required %b", ducking, mon_e.d);
        end
        n_vec++;
        if (game_frozen !== mon_e.f) begin
          n_err++; $display("[TB] FAIL sb_frozen: got %b required %b", game_frozen, mon_e.f);
        end
        n_vec++;
        if (game_restart !== mon_e.r) begin
          n_err++; $display("[TB] FAIL sb_restart: got %b required %b", game_restart, mon_e.r);
        end
      end
    end else begin
      n_vec++;
      if (game_restart !== 1'b0) begin
        n_err++; $display("[TB] FAIL restart_width: got %b required 0", game_restart);
      end
    end
  end

  task automatic land_bounded(input bit dn);
    for (int k = 0; k < 40 && jumping; k++) do_tick(0, 0, dn, 0);
    n_vec++;
    if (jumping !== 1'b0) begin
      n_err++; $display("[TB] FAIL land_timeout: jumping got %b required 0", jumping);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; game_tick = 0; button_start = 0; button_up = 0; button_down = 0; crash = 0;
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (player_y !== '0 || jumping !== 0 || ducking !== 0 || game_frozen !== 1 || game_restart !== 0) begin
      n_err++;
      $display("[TB] FAIL reset_vals: got y=%0d j=%b d=%b f=%b r=%b required 0 0 0 1 0",
               player_y, jumping, ducking, game_frozen, game_restart);
    end
    rst_n = 1'b1;
    do_tick(0, 1, 1, 1);
    n_vec++;
    if (game_frozen !== 1'b1) begin
      n_err++; $display("[TB] FAIL idle_ignores: frozen got %b required 1", game_frozen);
    end
  endtask

  task automatic test_start();
    do_tick(1, 0, 0, 0);
    n_vec++;
    if (game_frozen !== 1'b0) begin
      n_err++; $display("[TB] FAIL start_frozen: got %b required 0", game_frozen);
    end
  endtask

  task automatic test_jump_profile();
    int prof[17] = '{8, 15, 21, 26, 30, 33, 35, 36, 36, 35, 33, 30, 26, 21, 15, 8, 0};
    do_tick(0, 1, 0, 0);
    for (int i = 0; i < 17; i++) begin
      do_tick(0, 0, 0, 0);
      n_vec++;
      if (player_y !== prof[i][DEF_POS_W-1:0] || jumping !== (i < 16)) begin
        n_err++;
        $display("[TB] FAIL jump_profile[%0d]: got y=%0d j=%b required y=%0d j=%b",
                 i, player_y, jumping, prof[i], (i < 16));
      end
    end
  endtask

  task automatic test_fast_fall();
    int ff[6] = '{35, 31, 24, 14, 1, 0};
    do_tick(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) do_tick(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      do_tick(0, 0, 1, 0);
      n_vec++;
      if (player_y !== ff[i][DEF_POS_W-1:0]) begin
        n_err++; $display("[TB] FAIL fast_fall[%0d]: got y=%0d required %0d", i, player_y, ff[i]);
      end
    end
    n_vec++;
    if (ducking !== 1'b1 || jumping !== 1'b0) begin
      n_err++; $display("[TB] FAIL ff_land_duck: got d=%b j=%b required 1 0", ducking, jumping);
    end
    do_tick(0, 0, 0, 0);
  endtask

  task automatic test_crash();
    do_tick(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) do_tick(0, 0, 0, 0);
    do_tick(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      do_tick(0, i[0], i[1], i[2]);
      n_vec++;
      if (player_y !== 7'd26 || game_frozen !== 1'b1) begin
        n_err++; $display("[TB] FAIL dead_hold[%0d]: got y=%0d f=%b required 26 1", i, player_y, game_frozen);
      end
    end
    do_tick(1, 0, 0, 1);
    n_vec++;
    if (player_y !== '0 || game_frozen !== 1'b0) begin
      n_err++; $display("[TB] FAIL dead_restart: got y=%0d f=%b required 0 0", player_y, game_frozen);
    end
  endtask

  task automatic test_no_tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      button_start = 1'($urandom); button_up = 1'($urandom);
      button_down  = 1'($urandom); crash     = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if (player_y !== '0 || jumping !== 0 || ducking !== 0 || game_frozen !== 0) begin
        n_err++;
        $display("[TB] FAIL no_tick[%0d]: got y=%0d j=%b d=%b f=%b required 0 0 0 0",
                 i, player_y, jumping, ducking, game_frozen);
      end
    end
    button_start = 0; button_up = 0; button_down = 0; crash = 0;
  endtask

  task automatic test_up_and_down();
    do_tick(0, 1, 1, 0);
    n_vec++;
    if (jumping !== 1'b1 || ducking !== 1'b0) begin
      n_err++; $display("[TB] FAIL up_wins: got j=%b d=%b required 1 0", jumping, ducking);
    end
    land_bounded(0);
  endtask

  task automatic test_double_jump();
    int y6, y8, y2nd;
`ifdef DOUBLE_JUMP_EN
    y6 = 33; y8 = 48; y2nd = 23;
`else
    y6 = 33; y8 = 36; y2nd = 21;
`endif
    do_tick(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) do_tick(0, 0, 0, 0);
    do_tick(0, 1, 0, 0);
    n_vec++;
    if (player_y !== y6[DEF_POS_W-1:0]) begin
      n_err++; $display("[TB] FAIL dj_press: got y=%0d required %0d", player_y, y6);
    end
    do_tick(0, 0, 0, 0);
    do_tick(0, 1, 0, 0);
    n_vec++;
    if (player_y !== y8[DEF_POS_W-1:0]) begin
      n_err++; $display("[TB] FAIL dj_third_press: got y=%0d required %0d", player_y, y8);
    end
    land_bounded(0);
    do_tick(0, 1, 0, 0);
    do_tick(0, 0, 0, 0);
    do_tick(0, 1, 0, 0);
    do_tick(0, 0, 0, 0);
    n_vec++;
    if (player_y !== y2nd[DEF_POS_W-1:0]) begin
      n_err++; $display("[TB] FAIL dj_second_jump: got y=%0d required %0d", player_y, y2nd);
    end
    land_bounded(0);
  endtask

  task automatic test_back_to_back();
    do_tick(0, 1, 0, 0);
    for (int i = 0; i < 17; i++) do_tick(0, 1, 0, 0);
    n_vec++;
    if (jumping !== 1'b0 || player_y !== '0) begin
      n_err++; $display("[TB] FAIL held_up_land: got j=%b y=%0d required 0 0", jumping, player_y);
    end
    do_tick(0, 1, 0, 0);
    n_vec++;
    if (jumping !== 1'b1) begin
      n_err++; $display("[TB] FAIL relaunch: got j=%b required 1", jumping);
    end
    land_bounded(0);
  endtask

  task automatic test_reset_mid_jump();
    do_tick(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 0);
    n_vec++;
    if (player_y !== 7'd21) begin
      n_err++; $display("[TB] FAIL pre_reset_y: got %0d required 21", player_y);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (player_y !== '0 || game_frozen !== 1'b1 || jumping !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL async_reset: got y=%0d f=%b j=%b required 0 1 0", player_y, game_frozen, jumping);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_tick(1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_jump_profile();
    test_fast_fall();
    test_crash();
    test_no_tick();
    test_up_and_down();
    test_double_jump();
    test_back_to_back();
    test_reset_mid_jump();
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("[TB] FAIL sb_leftover: got %0d entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
